// File: rtl/clock_pkg.sv
// Shared constants for the digital clock stages: BCD digit type, digit limits
// and the encoding of the run/set key level.
package clock_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;
    localparam int   HR24_MAX     = 23;
    localparam int   HR12_MAX     = 12;

    typedef enum logic {
        KEY_SET = 1'b0,
        KEY_RUN = 1'b1
    } key_mode_e;

    // True when the two BCD digits spell the decimal value given.
    function automatic logic hr_is(bcd_t tens, bcd_t units, int value);
        return (tens == bcd_t'(value / 10)) && (units == bcd_t'(value % 10));
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchronizer followed by a registered rising-edge one-shot.
// A raw edge captured at clock edge N yields a pulse that is acted on at edge N+SYNC_STAGES+1.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_rise
);

    // Fewer than two stages is not a safe synchronizer, so clamp upward.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_last;
    logic              r_rise;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_btn};
            r_last <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_last;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/generate_min_hr.sv
// Minutes/hours stage of the digital clock: BCD counters advanced by the seconds
// carry in run mode or by debounced-free push-button edges in set mode.
module generate_min_hr
    import clock_pkg::*;
#(
    parameter bit HOUR_24     = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               min_en,
    input  logic               key,
    input  logic               btn_min,
    input  logic               btn_hr,
    output logic [DIGIT_W-1:0] m1,
    output logic [DIGIT_W-1:0] m2,
    output logic [DIGIT_W-1:0] h1,
    output logic [DIGIT_W-1:0] h2,
    output logic               pm,
    output logic               day_en
);

    localparam bcd_t RST_H2 = HOUR_24 ? 4'd0 : 4'd1;
    localparam bcd_t RST_H1 = HOUR_24 ? 4'd0 : 4'd2;

    bcd_t r_m1, r_m2, r_h1, r_h2;
    logic r_pm;
    logic r_day;

    logic w_btn_min_rise, w_btn_hr_rise;
    logic w_run;
    logic w_min_last;
    bcd_t w_m1_inc, w_m2_inc;
    bcd_t w_h1_inc, w_h2_inc;
    logic w_pm_inc;
    logic w_midnight;
    logic w_min_step, w_hr_step;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_btn     (btn_min),
        .o_rise    (w_btn_min_rise)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hr (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_btn     (btn_hr),
        .o_rise    (w_btn_hr_rise)
    );

    assign w_run      = (key_mode_e'(key) == KEY_RUN);
    assign w_min_last = (r_m1 == DIGIT_MAX) && (r_m2 == MIN_TENS_MAX);

    // Minute increment with the 59 -> 00 wrap; hour carry is decided separately.
    always_comb begin
        w_m1_inc = r_m1 + 4'd1;
        w_m2_inc = r_m2;
        if (r_m1 == DIGIT_MAX) begin
            w_m1_inc = 4'd0;
            w_m2_inc = (r_m2 == MIN_TENS_MAX) ? 4'd0 : r_m2 + 4'd1;
        end
    end

    // Hour increment; w_midnight flags the step that starts a new day.
    always_comb begin
        w_h1_inc   = r_h1 + 4'd1;
        w_h2_inc   = r_h2;
        w_pm_inc   = r_pm;
        w_midnight = 1'b0;
        if (HOUR_24) begin
            if (hr_is(r_h2, r_h1, HR24_MAX)) begin
                w_h1_inc   = 4'd0;
                w_h2_inc   = 4'd0;
                w_midnight = 1'b1;
            end else if (r_h1 == DIGIT_MAX) begin
                w_h1_inc = 4'd0;
                w_h2_inc = r_h2 + 4'd1;
            end
        end else begin
            if (hr_is(r_h2, r_h1, HR12_MAX)) begin
                w_h1_inc = 4'd1;
                w_h2_inc = 4'd0;
            end else if (hr_is(r_h2, r_h1, HR12_MAX - 1)) begin
                w_h1_inc   = 4'd2;
                w_h2_inc   = 4'd1;
                w_pm_inc   = ~r_pm;
                w_midnight = r_pm;
            end else if (r_h1 == DIGIT_MAX) begin
                w_h1_inc = 4'd0;
                w_h2_inc = 4'd1;
            end
        end
    end

    // In set mode the buttons step minutes and hours independently, with no carry.
    assign w_min_step = w_run ? min_en : w_btn_min_rise;
    assign w_hr_step  = w_run ? (min_en & w_min_last) : w_btn_hr_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m1  <= 4'd0;
            r_m2  <= 4'd0;
            r_h1  <= RST_H1;
            r_h2  <= RST_H2;
            r_pm  <= 1'b0;
            r_day <= 1'b0;
        end else begin
            r_day <= w_run & min_en & w_min_last & w_midnight;
            if (w_min_step) begin
                r_m1 <= w_m1_inc;
                r_m2 <= w_m2_inc;
            end
            if (w_hr_step) begin
                r_h1 <= w_h1_inc;
                r_h2 <= w_h2_inc;
                r_pm <= w_pm_inc;
            end
        end
    end

    assign m1     = r_m1;
    assign m2     = r_m2;
    assign h1     = r_h1;
    assign h2     = r_h2;
    assign pm     = HOUR_24 ? 1'b0 : r_pm;
    assign day_en = r_day;

endmodule

// File: tb/tb_generate_min_hr.sv
// Bench for generate_min_hr: a 24-hour and a 12-hour instance share one stimulus
// stream and are checked every cycle against a minutes-of-day reference model.
module tb_generate_min_hr;

    localparam int W  = 18;
    localparam int S0 = 2;
    localparam int S1 = 3;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic min_en  = 1'b0;
    logic key     = 1'b1;
    logic btn_min = 1'b0;
    logic btn_hr  = 1'b0;

    logic [3:0] m1_a, m2_a, h1_a, h2_a;
    logic [3:0] m1_b, m2_b, h1_b, h2_b;
    logic       pm_a, pm_b, day_a, day_b;

    generate_min_hr #(.HOUR_24(1'b1), .SYNC_STAGES(S0)) dut24 (
        .clk(clk), .reset(reset), .min_en(min_en), .key(key),
        .btn_min(btn_min), .btn_hr(btn_hr),
        .m1(m1_a), .m2(m2_a), .h1(h1_a), .h2(h2_a), .pm(pm_a), .day_en(day_a)
    );

    generate_min_hr #(.HOUR_24(1'b0), .SYNC_STAGES(S1)) dut12 (
        .clk(clk), .reset(reset), .min_en(min_en), .key(key),
        .btn_min(btn_min), .btn_hr(btn_hr),
        .m1(m1_b), .m2(m2_b), .h1(h1_b), .h2(h2_b), .pm(pm_b), .day_en(day_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: hour 0..23 and minute 0..59 per instance, plus raw button history
    // (bit k = value sampled k edges ago).
    int         hr_m[2];
    int         mn_m[2];
    logic [7:0] hb_min[2];
    logic [7:0] hb_hr[2];
    int         stg[2] = '{S0, S1};

    function automatic logic [W-1:0] bcd(logic day, logic p, logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c, logic [3:0] d);
        return {day, p, a, b, c, d};
    endfunction

    // Displayed digits for a time of day; instance 1 is the 12-hour clock.
    function automatic logic [W-1:0] disp(int d, int h, int m, logic day);
        int   hd;
        logic p;
        hd = h;
        p  = 1'b0;
        if (d == 1) begin
            hd = (h % 12 == 0) ? 12 : h % 12;
            p  = (h >= 12);
        end
        return {day, p, 4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [W-1:0] actual(int d);
        if (d == 0) return {day_a, pm_a, h2_a, h1_a, m2_a, m1_a};
        return {day_b, pm_b, h2_b, h1_b, m2_b, m1_b};
    endfunction

    task automatic compare(string tag, logic [W-1:0] got, logic [W-1:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hr_m[d]   = 0;
            mn_m[d]   = 0;
            hb_min[d] = '0;
            hb_hr[d]  = '0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock edge: advance the model with the inputs present at the edge, then check.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            logic rise_m, rise_h, day;
            int   s;
            s         = stg[d];
            hb_min[d] = {hb_min[d][6:0], btn_min};
            hb_hr[d]  = {hb_hr[d][6:0], btn_hr};
            rise_m    = hb_min[d][s+1] & ~hb_min[d][s+2];
            rise_h    = hb_hr[d][s+1] & ~hb_hr[d][s+2];
            day       = 1'b0;
            if (key) begin
                if (min_en) begin
                    if (mn_m[d] == 59) begin
                        mn_m[d] = 0;
                        if (hr_m[d] == 23) day = 1'b1;
                        hr_m[d] = (hr_m[d] + 1) % 24;
                    end else begin
                        mn_m[d]++;
                    end
                end
            end else begin
                if (rise_m) mn_m[d] = (mn_m[d] + 1) % 60;
                if (rise_h) hr_m[d] = (hr_m[d] + 1) % 24;
            end
            exp_q.push_back(disp(d, hr_m[d], mn_m[d], day));
        end
        #1;
        for (int d = 0; d < 2; d++) compare($sformatf("cycle_dut%0d", d), actual(d), exp_q.pop_front());
    endtask

    task automatic do_reset();
        btn_min = 1'b0;
        btn_hr  = 1'b0;
        min_en  = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare("rst_async_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        compare("rst_async_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0));
        @(posedge clk);
        #1;
        compare("rst_hold_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        compare("rst_hold_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0));
        #2 reset = 1'b1;
    endtask

    task automatic run_min(int n, bit gap);
        key = 1'b1;
        repeat (n) begin
            min_en = 1'b1;
            step();
            if (gap) begin
                min_en = 1'b0;
                step();
            end
        end
        min_en = 1'b0;
    endtask

    task automatic flush();
        btn_min = 1'b0;
        btn_hr  = 1'b0;
        repeat (8) step();
    endtask

    // One-cycle button pulses in set mode, with stray min_en activity that must be ignored.
    task automatic press(bit on_min, bit on_hr, int n);
        repeat (n) begin
            btn_min = on_min;
            btn_hr  = on_hr;
            min_en  = 1'($urandom_range(0, 1));
            step();
            btn_min = 1'b0;
            btn_hr  = 1'b0;
            min_en  = 1'($urandom_range(0, 1));
            step();
        end
        min_en = 1'b0;
    endtask

    task automatic set_time(int h, int m);
        key    = 1'b0;
        min_en = 1'b0;
        step();
        press(1'b0, 1'b1, (h - hr_m[0] + 24) % 24);
        press(1'b1, 1'b0, (m - mn_m[0] + 60) % 60);
        flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence, then random ----------------
    initial begin
        do_reset();

        // 60 spaced minute pulses from midnight reach the next hour
        run_min(60, 1'b1);
        compare("hour1_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0));
        compare("hour1_12", actual(1), bcd(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0));

        // Preload 23:59 with the buttons, then roll over midnight
        set_time(23, 59);
        compare("pre2359_24", actual(0), bcd(1'b0, 1'b0, 4'h2, 4'h3, 4'h5, 4'h9));
        compare("pre2359_12", actual(1), bcd(1'b0, 1'b1, 4'h1, 4'h1, 4'h5, 4'h9));
        run_min(1, 1'b0);
        compare("midnight_24", actual(0), bcd(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        compare("midnight_12", actual(1), bcd(1'b1, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0));
        step();
        compare("day_drop_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
        compare("day_drop_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0));

        // 11:59 AM -> 12:00 PM, then 12:59 -> 01:00 PM with back-to-back pulses
        set_time(11, 59);
        run_min(1, 1'b0);
        compare("noon_24", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h0));
        compare("noon_12", actual(1), bcd(1'b0, 1'b1, 4'h1, 4'h2, 4'h0, 4'h0));
        run_min(60, 1'b0);
        compare("one_pm_24", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h3, 4'h0, 4'h0));
        compare("one_pm_12", actual(1), bcd(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0));

        // Set mode at 10:59: latency of a minute press, then a long hold counts once
        set_time(10, 59);
        btn_min = 1'b1;
        repeat (3) step();
        compare("btn_lat_before", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h0, 4'h5, 4'h9));
        step();
        compare("btn_lat_after", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0));
        repeat (96) begin
            min_en = 1'($urandom_range(0, 1));
            step();
        end
        min_en = 1'b0;
        flush();
        compare("hold_once_24", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0));
        compare("hold_once_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0));

        // Both buttons in the same cycle at 05:59
        set_time(5, 59);
        press(1'b1, 1'b1, 1);
        flush();
        compare("both_btn_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h6, 4'h0, 4'h0));
        compare("both_btn_12", actual(1), bcd(1'b0, 1'b0, 4'h0, 4'h6, 4'h0, 4'h0));

        // Hour button at 23:17 wraps to 00:17 without a day pulse
        set_time(23, 17);
        press(1'b0, 1'b1, 1);
        flush();
        compare("hr_wrap_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h7));
        compare("hr_wrap_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h1, 4'h7));

        // Asynchronous reset mid-count at 14:37
        set_time(14, 30);
        run_min(7, 1'b0);
        compare("at1437_24", actual(0), bcd(1'b0, 1'b0, 4'h1, 4'h4, 4'h3, 4'h7));
        compare("at1437_12", actual(1), bcd(1'b0, 1'b1, 4'h0, 4'h2, 4'h3, 4'h7));
        key    = 1'b1;
        min_en = 1'b1;
        do_reset();
        run_min(1, 1'b0);
        compare("post_rst_24", actual(0), bcd(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1));
        compare("post_rst_12", actual(1), bcd(1'b0, 1'b0, 4'h1, 4'h2, 4'h0, 4'h1));

        // Random phase starting near midnight: key toggles, carries and button edges
        set_time(23, 50);
        key = 1'b1;
        repeat (2000) begin
            if ($urandom_range(0, 40) == 0) key = ~key;
            min_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) btn_min = ~btn_min;
            if ($urandom_range(0, 3) == 0) btn_hr = ~btn_hr;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/generate_min_hr.md
# generate_min_hr

Minutes/hours stage of the digital clock, directly downstream of the seconds generator. Consumes the seconds stage's one-cycle `min_en` carry pulse and the shared `key` run/set level. Maintains BCD minutes and hours, and supports manual time setting via two push-buttons. Emits a one-cycle `day_en` pulse on midnight rollover for any later date stage.

## Interface
Parameters:
- `HOUR_24`, default 1: 1 = 00–23 hour range; 0 = 12-hour range 12,1..11 with `pm` flag.
- `SYNC_STAGES`, default 2: synchronizer flops on each button input, minimum 2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `min_en`  in  1  one-cycle pulse from seconds stage at seconds 59→00; synchronous to `clk`.
- `key`  in  1  1 = run (count), 0 = set mode; same signal as feeds the seconds stage.
- `btn_min`  in  1  raw minute-advance button, asynchronous, active-high.
- `btn_hr`  in  1  raw hour-advance button, asynchronous, active-high.
- `m1`  out  4  minutes units digit, BCD 0–9.
- `m2`  out  4  minutes tens digit, BCD 0–5.
- `h1`  out  4  hours units digit, BCD.
- `h2`  out  4  hours tens digit, BCD 0–2 (0–1 when `HOUR_24`=0).
- `pm`  out  1  PM flag; tied 0 when `HOUR_24`=1.
- `day_en`  out  1  one-cycle pulse on midnight rollover.

## Operation
- Reset values:
  - `HOUR_24`=1: 00:00.
  - `HOUR_24`=0: 12:00, `pm`=0.
  - `day_en`=0; synchronizer and edge-detect flops = 0.
- Run mode (`key`=1): each cycle with `min_en`=1 advances time by one minute.
  - `m1` 9→0 carries into `m2`.
  - `m2:m1` 59→00 advances the hour.
- 24h hour advance:
  - `h1` 9→0 with `h2`+1.
  - 23→00 raises `day_en`.
- 12h hour advance:
  - 12→01.
  - 09→10.
  - 11→12 toggles `pm`.
  - `day_en` fires only on 11 PM→12 AM, i.e. when `pm` goes 1→0.
- Set mode (`key`=0):
  - `min_en` is ignored; no minute is lost or queued.
  - Synchronized rising edge of `btn_min`: minutes +1, wrap 59→00, no carry into hours.
  - Synchronized rising edge of `btn_hr`: hour advance per the rules above, including `pm` toggle. `day_en` is never asserted in set mode.
- Button edges while `key`=1 are ignored.
- Button held high gives exactly one increment; no auto-repeat.
- Simultaneous `btn_min` and `btn_hr` edges in the same cycle: both applied, minutes wrap independently of hours.
- `key` toggling: takes effect on the next edge; no internal state besides the counters.
- Digits are never outside their legal BCD range. Any illegal register value is unreachable; no recovery logic is required.

## Timing
- `min_en` high at edge N: new time visible after edge N; `day_en` high for exactly the cycle after edge N, aligned with the 00:00 / 12:00 AM outputs.
- Button path: `SYNC_STAGES` flops, then an edge-detect flop. An edge captured at edge N applies at edge N+`SYNC_STAGES`+1.
- Back-to-back `min_en` on consecutive cycles: each one counts.
- Async reset assertion mid-count clears outputs without waiting for `clk`. Deassertion is assumed synchronized externally.

## Structure
- Shared package `clock_pkg`:
  - BCD digit width (4).
  - Limit constants: `MIN_TENS_MAX`=5, `DIGIT_MAX`=9, `HR24_MAX`=23, `HR12_MAX`=12.
  - Mode encoding of `key` (`KEY_RUN`=1, `KEY_SET`=0), shared with the seconds stage.
- One sub-module `btn_sync_edge`: parameterised synchronizer plus rising-edge one-shot. Instantiated twice.
- Minute/hour counters are inline in `generate_min_hr`.

## Test plan
- Reset then run (`HOUR_24`=1): 60 `min_en` pulses → 01:00; `day_en` never high.
- Preload via buttons to 23:59, set `key`=1, one `min_en` → 00:00 next cycle, `day_en`=1 for exactly one cycle.
- `HOUR_24`=0: from 11:59 AM one `min_en` → 12:00, `pm`=1. From 11:59 PM one `min_en` → 12:00 AM with `day_en` pulse. From 12:59 → 01:00.
- Set mode at 10:59: `btn_min` pulse → 10:00 after `SYNC_STAGES`+1 cycles. `btn_min` held 100 cycles → single increment. Concurrent `min_en` pulses → no change.
- Both buttons rising in the same cycle at 05:59 → 06:00. `btn_hr` at 23:xx → 00:xx with `day_en` held 0.
- `reset` pulled low mid-count at 14:37, between clock edges → outputs 00:00 immediately. Release and 1 `min_en` → 00:01.
